// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU definitions: operation encoding, datapath width,
//            reserved-op threshold and the arbiter's FSM state type.
//            Imported by the ALU decode and by alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  // Encodings at or above this value are reserved; the ALU returns 0.
  localparam logic [3:0] ALU_OP_RSVD_MIN = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  function automatic logic op_is_rsvd(input logic [3:0] op);
    return (op >= ALU_OP_RSVD_MIN);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin arbiter. The search starts at
//            last_grant+1 and wraps modulo N; the first asserted request wins.
// Ports    : req        in  N    request vector
//            last_grant in  IDW  index of the most recent grant
//            gnt        out N    zero or one-hot grant
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   gnt
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // Offsets 1..N visit every requester once, ending on last_grant itself
    // so a lone requester can be granted back to back.
    for (int off = 1; off <= N; off++) begin
      w_idx = IDW'((int'(last_grant) + off) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU among NUM_REQ requesters. One op is
//            accepted per grant (valid/ready), the ALU inputs are driven in
//            the accept cycle, and the result is captured in a one-entry
//            response buffer returned over a per-requester valid/ready link.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            req_valid_i/req_ready_o per-requester op handshake
//            req_op_i/req_a_i/req_b_i per-requester op and operands (sliced)
//            rsp_valid_o/rsp_ready_i per-requester response handshake
//            rsp_data_o, rsp_err_o   registered result / reserved-op flag
//            alu_op_o, operand_a_o, operand_b_o, alu_data_i  ALU interface
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [4*NUM_REQ-1:0]    req_op_i,
  input  logic [XLEN*NUM_REQ-1:0] req_a_i,
  input  logic [XLEN*NUM_REQ-1:0] req_b_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]         rsp_data_o,
  output logic                    rsp_err_o,
  output logic [3:0]              alu_op_o,
  output logic [XLEN-1:0]         operand_a_o,
  output logic [XLEN-1:0]         operand_b_o,
  input  logic [XLEN-1:0]         alu_data_i
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDW-1:0]   r_rsp_id;
  logic [IDW-1:0]   r_last_grant;
  logic [XLEN-1:0]  r_rsp_data;
  logic             r_rsp_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_resp_active;
  logic               w_rsp_hs;
  logic               w_can_accept;
  logic               w_accept;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (r_last_grant),
    .gnt        (w_gnt)
  );

  // Responses and accepts are both suppressed while reset is held so the
  // reset cycle shows no handshakes at all.
  assign w_resp_active = (r_state == ST_RESP) && !rst_i;
  // Only the target requester's ready matters; other rsp_ready_i bits are
  // never looked at.
  assign w_rsp_hs      = w_resp_active && rsp_ready_i[r_rsp_id];
  assign w_can_accept  = !rst_i && ((r_state == ST_IDLE) || w_rsp_hs);
  assign req_ready_o   = w_can_accept ? w_gnt : '0;
  assign w_accept      = |(req_valid_i & req_ready_o);

  // Operand mux from the granted slice; zeros when nothing is granted so the
  // ALU never sees X.
  always_comb begin
    alu_op_o    = 4'd0;
    operand_a_o = '0;
    operand_b_o = '0;
    w_gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        alu_op_o    = req_op_i[4*i +: 4];
        operand_a_o = req_a_i[XLEN*i +: XLEN];
        operand_b_o = req_b_i[XLEN*i +: XLEN];
        w_gnt_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (w_resp_active) begin
      rsp_valid_o[r_rsp_id] = 1'b1;
    end
  end

  assign rsp_data_o = r_rsp_data;
  assign rsp_err_o  = r_rsp_err;

  // Next-state: a new accept always lands in RESP, which covers the
  // back-to-back case (handshake and accept in the same cycle).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)              w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_hs && !w_accept) w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_rsp_id     <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_data   <= alu_data_i;
        r_rsp_err    <= op_is_rsvd(alu_op_o);
        r_rsp_id     <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
      end
    end
  end

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter (NUM_REQ=3) with a
//            behavioural ALU, a round-robin reference model and a response
//            scoreboard, followed by directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int N   = 3;
  localparam int IDW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [4*N-1:0]    req_op_i;
  logic [32*N-1:0]   req_a_i;
  logic [32*N-1:0]   req_b_i;
  logic [N-1:0]      rsp_valid_o;
  logic [N-1:0]      rsp_ready_i;
  logic [31:0]       rsp_data_o;
  logic              rsp_err_o;
  logic [3:0]        alu_op_o;
  logic [31:0]       operand_a_o;
  logic [31:0]       operand_b_o;
  logic [31:0]       alu_data_i;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t sb[$];
  rsp_t rsp_log[$];
  int   gnt_log[$];
  int   m_last = N - 1;

  alu_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .alu_op_o    (alu_op_o),
    .operand_a_o (operand_a_o),
    .operand_b_o (operand_b_o),
    .alu_data_i  (alu_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: return (a < b) ? 32'd1 : 32'd0;
      4'd4: return a ^ b;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_data_i = alu_ref(alu_op_o, operand_a_o, operand_b_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rsp(input string name, input int idx, input logic [1:0] id,
                         input logic [31:0] data, input logic err);
    if (idx < rsp_log.size()) begin
      chk({name, "_id"},   32'(rsp_log[idx].id), 32'(id));
      chk({name, "_data"}, rsp_log[idx].data, data);
      chk({name, "_err"},  32'(rsp_log[idx].err), 32'(err));
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: response %0d missing, got %0d responses", name, idx, rsp_log.size());
    end
  endtask

  // Reference monitor: predicts grants with a plain modulo scan, tracks the
  // pending response in a queue and compares everything the DUT presents.
  always @(negedge clk_i) begin
    int          g;
    int          idx;
    bit          hs;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    rsp_t        e;
    if (rst_i) begin
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      sb.delete();
      m_last = N - 1;
    end else begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (g < 0 && req_valid_i[idx]) g = idx;
      end
      hs      = (sb.size() != 0) && rsp_ready_i[sb[0].id];
      exp_rdy = ((sb.size() == 0 || hs) && g >= 0) ? N'(1 << g) : '0;
      exp_rv  = (sb.size() != 0) ? N'(1 << sb[0].id) : '0;
      chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
      if (req_valid_i == '0) begin
        chk("idle_alu", {28'd0, alu_op_o} | operand_a_o | operand_b_o, 32'd0);
      end
      if (sb.size() != 0) begin
        chk("rsp_data", rsp_data_o, sb[0].data);
        chk("rsp_err", 32'(rsp_err_o), 32'(sb[0].err));
        if (hs) rsp_log.push_back(sb.pop_front());
      end
      if (exp_rdy != '0) begin
        e.id   = g[1:0];
        e.data = alu_ref(req_op_i[4*g +: 4], req_a_i[32*g +: 32], req_b_i[32*g +: 32]);
        e.err  = (req_op_i[4*g +: 4] >= 4'd10);
        sb.push_back(e);
        gnt_log.push_back(g);
        m_last = g;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid_i[i]      = v;
    req_op_i[4*i +: 4]  = op;
    req_a_i[32*i +: 32] = a;
    req_b_i[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = '0;
    step();
    rst_i       = 1'b0;
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    gnt_log.delete();
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    rsp_ready_i = '0;
    step(); step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_data", rsp_data_o, 32'd0);
    chk("reset_err", 32'(rsp_err_o), 32'd0);
    chk("reset_rv", 32'(rsp_valid_o), 32'd0);
    step();

    // Single request, response held until rsp_ready_i[0]
    clear_logs();
    set_req(0, 1, 4'd0, 32'd5, 32'd7);
    @(negedge clk_i);
    chk("t1_ready", 32'(req_ready_o), 32'b001);
    step();
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      chk("t1_hold_rv", 32'(rsp_valid_o), 32'b001);
      chk("t1_hold_data", rsp_data_o, 32'd12);
      step();
    end
    rsp_ready_i = 3'b001;
    step();
    rsp_ready_i = '0;
    chk_rsp("t1", 0, 2'd0, 32'd12, 1'b0);

    // Contention with back-to-back throughput
    do_reset();
    clear_logs();
    rsp_ready_i = '1;
    set_req(0, 1, 4'd1, 32'd3, 32'd5);
    set_req(1, 1, 4'd3, 32'd1, 32'hFFFF_FFFF);
    step();
    @(negedge clk_i);
    chk("t2_ready1", 32'(req_ready_o), 32'b010);
    step();
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    step(); step();
    chk("t2_g0", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'd0);
    chk("t2_g1", 32'(gnt_log.size() > 1 ? gnt_log[1] : -1), 32'd1);
    chk_rsp("t2_r0", 0, 2'd0, 32'hFFFF_FFFE, 1'b0);
    chk_rsp("t2_r1", 1, 2'd1, 32'd1, 1'b0);

    // Backpressure on requester 0 while requester 1 waits
    clear_logs();
    rsp_ready_i = '0;
    set_req(0, 1, 4'd4, 32'h0000_F0F0, 32'h0000_0FF0);
    set_req(1, 1, 4'd0, 32'd1, 32'd1);
    @(negedge clk_i);
    chk("t3_ready0", 32'(req_ready_o), 32'b001);
    step();
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_stall_ready", 32'(req_ready_o), 32'd0);
      chk("t3_stall_data", rsp_data_o, 32'h0000_FF00);
      step();
    end
    rsp_ready_i = 3'b001;
    @(negedge clk_i);
    chk("t3_ready1", 32'(req_ready_o), 32'b010);
    step();
    rsp_ready_i = '1;
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    step(); step();
    chk_rsp("t3_r0", 0, 2'd0, 32'h0000_FF00, 1'b0);
    chk_rsp("t3_r1", 1, 2'd1, 32'd2, 1'b0);

    // Reserved op and shifts, one op per cycle from requester 0
    clear_logs();
    set_req(0, 1, 4'hC, 32'd123, 32'd456);        step();
    set_req(0, 1, 4'd9, 32'h8000_0000, 32'd4);    step();
    set_req(0, 1, 4'd7, 32'd3, 32'd33);           step();
    set_req(0, 0, 4'd0, 32'd0, 32'd0);            step(); step();
    chk_rsp("t4_rsvd", 0, 2'd0, 32'd0, 1'b1);
    chk_rsp("t4_sra", 1, 2'd0, 32'hF800_0000, 1'b0);
    chk_rsp("t4_sll", 2, 2'd0, 32'd6, 1'b0);

    // Fairness with all three requesters valid
    do_reset();
    clear_logs();
    rsp_ready_i = '1;
    for (int i = 0; i < N; i++) set_req(i, 1, 4'(i + 4), 32'($urandom), 32'($urandom));
    repeat (6) step();
    req_valid_i = '0;
    step(); step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_order%0d", i), 32'(gnt_log.size() > i ? gnt_log[i] : -1), 32'(i % N));
    end

    // Reset while requester 1's response is pending
    clear_logs();
    rsp_ready_i = '0;
    set_req(1, 1, 4'd0, 32'd9, 32'd9);
    step();
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    @(negedge clk_i);
    chk("t6_pending", 32'(rsp_valid_o), 32'b010);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    rsp_ready_i = '1;
    set_req(0, 1, 4'd5, 32'd1, 32'd2);
    set_req(1, 1, 4'd6, 32'd3, 32'd1);
    @(negedge clk_i);
    chk("t6_after_rv", 32'(rsp_valid_o), 32'd0);
    chk("t6_prio0", 32'(req_ready_o), 32'b001);
    step();
    req_valid_i = '0;
    step(); step();
    chk("t6_dropped", 32'(rsp_log.size()), 32'd1);

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                32'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom));
      end
      for (int i = 0; i < N; i++) rsp_ready_i[i] = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid_i = '0;
    rsp_ready_i = '1;
    repeat (4) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters, for example the integer pipe and an address or branch helper.
- Accepts one operation per grant using a valid/ready handshake and drives the ALU operand and op inputs combinationally in the accept cycle.
- Registers alu_data into a one-entry response buffer and returns it to the granted requester through a per-requester valid/ready response handshake.
- Round-robin fairness.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDW, 1, requester index width, equal to $clog2(NUM_REQ).

Ports:
- clk_i  in  1  clock. One clock domain.
- rst_i  in  1  reset, synchronous and active-high.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept. Zero or one-hot.
- req_op_i  in  4*NUM_REQ  per-requester alu_op; slice i = [4i+3:4i].
- req_a_i  in  32*NUM_REQ  per-requester operand_a.
- req_b_i  in  32*NUM_REQ  per-requester operand_b.
- rsp_valid_o  out  NUM_REQ  response valid. Zero or one-hot.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_data_o  out  32  registered ALU result, shared by all requesters.
- rsp_err_o  out  1  registered flag: the accepted op was reserved (4'b1010..4'b1111).
- alu_op_o  out  4  to ALU alu_op.
- operand_a_o  out  32  to ALU operand_a.
- operand_b_o  out  32  to ALU operand_b.
- alu_data_i  in  32  from ALU alu_data.

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA.
  - 10..15 reserved; the ALU returns 0 for these.
- States: IDLE, RESP.
- can_accept = (state==IDLE) | (state==RESP & rsp_valid_o[rsp_id] & rsp_ready_i[rsp_id]).
- Arbitration:
  - Round-robin; search starts at last_grant+1 and wraps modulo NUM_REQ.
  - gnt is one-hot over req_valid_i.
  - req_ready_o = gnt when can_accept, else 0.
  - req_ready_o never depends on rsp_ready_i of a different requester.
- ALU drive:
  - alu_op_o, operand_a_o and operand_b_o are muxed from the granted slice.
  - When there is no grant, drive op 0 and operands 0; the outputs must never be X.
- Accept (req_valid_i[g] & req_ready_o[g]):
  - rsp_data_o <= alu_data_i.
  - rsp_err_o <= (op >= 10).
  - rsp_id <= g; last_grant <= g; state <= RESP.
- RESP:
  - rsp_valid_o[rsp_id] = 1.
  - rsp_data_o, rsp_err_o and rsp_id are held stable until rsp_ready_i[rsp_id].
  - On the response handshake with no new accept: state <= IDLE.
  - On the response handshake with a new accept in the same cycle: stay in RESP with the new data. This gives throughput of 1 op per cycle.
- Latency: request accepted in cycle N, response valid in cycle N+1.
- rsp_ready_i bits of non-target requesters are ignored.
- A requester that deasserts req_valid_i without a handshake is legal: no grant, and last_grant is unchanged.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 accepts.
- last_grant updates only on an accept, never on idle cycles.
- Reset:
  - state=IDLE, rsp_valid_o=0, req_ready_o=0 in the reset cycle.
  - rsp_data_o=0, rsp_err_o=0, rsp_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-RESP drops the pending response with no handshake.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum, values 0..9 as listed under Behaviour.
  - ALU_OP_RSVD_MIN=4'd10.
  - XLEN=32.
  - The ALU decode and this block both import it.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], last_grant.
  - Output: gnt[N], one-hot, purely combinational.
  - The alu_arbiter top holds the FSM, response buffer and operand mux.

Test Plan:
- Reset, then single request: req0 ADD a=5, b=7 -> ready0 in the same cycle; rsp_valid_o=01 next cycle with data=12, err=0; held until rsp_ready_i[0].
- Contention: both requesters valid; req0 SUB 3-5, req1 SLTU a=1, b=0xFFFFFFFF, rsp_ready tied high.
  - Requester 0 is granted first, response 0xFFFFFFFE.
  - Requester 1 is granted the next cycle, response 1.
  - Throughput 1 op per cycle.
- Backpressure: req0 XOR 0xF0F0 ^ 0x0FF0 with rsp_ready_i[0]=0 for 3 cycles, req1 valid throughout.
  - req_ready_o=00 during the stall; rsp_data_o stable at 0xFF00.
  - Requester 1 is granted in the same cycle rsp_ready_i[0] rises.
- Fairness, NUM_REQ=3, all valid for 6 accepts -> grant order 0,1,2,0,1,2.
- Reserved op and shifts:
  - op=4'b1100 -> data=0, err=1.
  - SRA a=0x80000000, b=4 -> 0xF8000000, err=0.
  - SLL b=33 -> amount 1.
- Reset mid-RESP: assert rst_i while rsp_valid_o=10 -> next cycle rsp_valid_o=00, IDLE, and requester 0 has priority again.
